// File: rtl/fifo_sync_pkt_pkg.sv
// Shared constants and helpers for the packet-aware synchronous FIFO.
package fifo_sync_pkt_pkg;

    // Smallest address width that still gives a two-entry FIFO.
    localparam int EA_MIN = 1;

    // Largest supported address width.
    localparam int EA_MAX = 16;

    // Number of storage entries for a given address width.
    function automatic int fifo_depth(input int ea);
        return 1 << ea;
    endfunction

endpackage

// File: rtl/fifo_sync_pkt_ram.sv
// Simple dual-port storage: one write port and one registered read port.
// The read register is resettable so the FIFO's read data comes out of
// reset as zero. The array itself is not reset.
module fifo_sync_pkt_ram
    import fifo_sync_pkt_pkg::*;
#(
    parameter int W  = 9,
    parameter int AW = EA_MIN
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [fifo_depth(AW)];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port. It re-reads every cycle, so a stalled address
    // simply returns the same word again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rdata <= '0;
        else       rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_sync_pkt.sv
// Single-clock FIFO with an optional packet mode. In packet mode a word
// becomes readable only after the packet's last word is accepted, so an
// aborted (i_drop) or oversize packet never reaches the reader.
// Three pointers, each with a wrap bit:
//   wptr - next write slot
//   wcom - end of committed data
//   rptr - next read slot
module fifo_sync_pkt
    import fifo_sync_pkt_pkg::*;
#(
    parameter int DW    = 8,
    parameter int EA    = 10,
    parameter bit PKT   = 1'b0,
    parameter int AF_TH = fifo_depth(EA) - 4,
    parameter int AE_TH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          i_rdy,
    input  logic          i_en,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_drop,
    input  logic          o_rdy,
    output logic          o_en,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic [EA:0]   count,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          oversize
);

    typedef enum logic {
        ST_WRITE   = 1'b0,
        ST_DISCARD = 1'b1
    } wr_state_e;

    localparam logic [EA:0] AF_V = (EA+1)'(AF_TH);
    localparam logic [EA:0] AE_V = (EA+1)'(AE_TH);

    wr_state_e   state;
    logic [EA:0] wptr, wcom, rptr, wvis, rnext;
    logic        full, accept, we;
    logic [DW:0] rd_word;

    // Full when the pointers differ only in the wrap bit.
    assign full   = (wptr == {~rptr[EA], rptr[EA-1:0]});
    assign i_rdy  = (state == ST_DISCARD) | ~full;
    assign accept = i_en & i_rdy;

    // Uncommitted words count as occupancy: they hold real storage.
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AF_V);
    assign almost_empty = (count <= AE_V);

    // The read pointer advances on a handshake. The RAM is addressed with
    // the post-handshake pointer so the next word is ready after the edge.
    assign rnext = rptr + {{EA{1'b0}}, o_en & o_rdy};

    // A word dropped in the same cycle is never stored. Words that arrive
    // while discarding are sunk without touching the RAM.
    assign we = accept & (state == ST_WRITE) & ~(PKT & i_drop);

    // Write side: pointer bookkeeping and the packet-mode commit/discard FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            wcom     <= '0;
            state    <= ST_WRITE;
            oversize <= 1'b0;
        end else begin
            oversize <= 1'b0;
            if (!PKT) begin
                // Stream mode: every accepted word is committed at once.
                if (accept) begin
                    wptr <= wptr + 1'b1;
                    wcom <= wptr + 1'b1;
                end
            end else begin
                case (state)
                    ST_WRITE: begin
                        if (i_drop) begin
                            wptr <= wcom;
                        end else if (full && (wcom == rptr)) begin
                            // This packet alone filled the FIFO. Waiting for
                            // the reader would deadlock, so discard it and
                            // sink the rest of it.
                            wptr  <= wcom;
                            state <= ST_DISCARD;
                        end else if (accept) begin
                            wptr <= wptr + 1'b1;
                            if (i_last) wcom <= wptr + 1'b1;
                        end
                    end
                    ST_DISCARD: begin
                        if (i_drop) begin
                            state <= ST_WRITE;
                        end else if (accept && i_last) begin
                            oversize <= 1'b1;
                            state    <= ST_WRITE;
                        end
                    end
                    default: state <= ST_WRITE;
                endcase
            end
        end
    end

    // Read side. wvis is a one-cycle-delayed copy of wcom, so data that is
    // committed at edge k shows up on o_en after edge k+2.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr <= '0;
            wvis <= '0;
            o_en <= 1'b0;
        end else begin
            rptr <= rnext;
            wvis <= wcom;
            o_en <= (rnext != wvis);
        end
    end

    fifo_sync_pkt_ram #(
        .W  (DW + 1),
        .AW (EA)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we),
        .waddr (wptr[EA-1:0]),
        .wdata ({i_last, i_data}),
        .raddr (rnext[EA-1:0]),
        .rdata (rd_word)
    );

    assign {o_last, o_data} = rd_word;

endmodule

// File: tb/tb_fifo_sync_pkt.sv
// Bench for fifo_sync_pkt. Two 4-entry instances share one stimulus bus:
//   sel = 0 selects the stream-mode instance
//   sel = 1 selects the packet-mode instance
// A queue-based model predicts every output on every cycle. Directed
// sections then pin the model with literal expectations.
module tb_fifo_sync_pkt;

    localparam int DEPTH = 4;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       sel  = 1'b0;
    logic       en   = 1'b0;
    logic       last = 1'b0;
    logic       drop = 1'b0;
    logic       ordy = 1'b0;
    logic [7:0] data = '0;

    logic       rdy0, rdy1, oen0, oen1, olast0, olast1;
    logic       af0, af1, ae0, ae1, ovs0, ovs1;
    logic [7:0] od0, od1;
    logic [2:0] cnt0, cnt1;

    logic       act_rdy, act_oen, act_olast, act_af, act_ae, act_ovs;
    logic [7:0] act_od;
    logic [2:0] act_cnt;

    int checks = 0;
    int errors = 0;
    int maxcnt = 0;
    int ovs_cnt = 0;

    always #5 clk = ~clk;

    fifo_sync_pkt #(.DW(8), .EA(2), .PKT(1'b0), .AF_TH(4), .AE_TH(1)) u_str (
        .clk(clk), .rstn(rstn), .i_rdy(rdy0),
        .i_en(en & ~sel), .i_data(data), .i_last(last), .i_drop(drop & ~sel),
        .o_rdy(ordy & ~sel), .o_en(oen0), .o_data(od0), .o_last(olast0),
        .count(cnt0), .almost_full(af0), .almost_empty(ae0), .oversize(ovs0)
    );

    fifo_sync_pkt #(.DW(8), .EA(2), .PKT(1'b1), .AF_TH(3), .AE_TH(1)) u_pkt (
        .clk(clk), .rstn(rstn), .i_rdy(rdy1),
        .i_en(en & sel), .i_data(data), .i_last(last), .i_drop(drop & sel),
        .o_rdy(ordy & sel), .o_en(oen1), .o_data(od1), .o_last(olast1),
        .count(cnt1), .almost_full(af1), .almost_empty(ae1), .oversize(ovs1)
    );

    assign act_rdy   = sel ? rdy1   : rdy0;
    assign act_oen   = sel ? oen1   : oen0;
    assign act_od    = sel ? od1    : od0;
    assign act_olast = sel ? olast1 : olast0;
    assign act_cnt   = sel ? cnt1   : cnt0;
    assign act_af    = sel ? af1    : af0;
    assign act_ae    = sel ? ae1    : ae0;
    assign act_ovs   = sel ? ovs1   : ovs0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model state, all in terms of whole words:
    //   cq     - committed, unread words in order
    //   pq     - words of the packet still being written
    //   tc     - running total of committed words
    //   tc_p1  - the value tc had one edge earlier
    //   rd_tot - running total of words read
    // A committed word becomes readable two edges after it is committed.
    logic [8:0] cq[$];
    logic [8:0] pq[$];
    logic [8:0] got[$];
    bit         m_disc = 1'b0;
    bit         m_oen  = 1'b0;
    bit         m_ovs  = 1'b0;
    logic [8:0] m_out  = '0;
    int         tc = 0, tc_p1 = 0, rd_tot = 0;

    task automatic model_reset();
        cq.delete();
        pq.delete();
        m_disc = 1'b0;
        m_oen  = 1'b0;
        m_ovs  = 1'b0;
        tc     = 0;
        tc_p1  = 0;
        rd_tot = 0;
    endtask

    task automatic model_step();
        int n;
        bit acc;
        n   = cq.size() + pq.size();
        acc = en && (m_disc || n < DEPTH);
        if (m_oen && ordy) begin
            void'(cq.pop_front());
            rd_tot++;
        end
        m_oen = (tc_p1 - rd_tot) > 0;
        if (m_oen) m_out = cq[0];
        tc_p1 = tc;
        m_ovs = 1'b0;
        if (!sel) begin
            if (acc) begin
                cq.push_back({last, data});
                tc++;
            end
        end else if (m_disc) begin
            if (drop) begin
                m_disc = 1'b0;
            end else if (acc && last) begin
                m_disc = 1'b0;
                m_ovs  = 1'b1;
            end
        end else if (drop) begin
            pq.delete();
        end else if (pq.size() == DEPTH) begin
            pq.delete();
            m_disc = 1'b1;
        end else if (acc) begin
            pq.push_back({last, data});
            if (last) begin
                while (pq.size() > 0) begin
                    cq.push_back(pq.pop_front());
                    tc++;
                end
            end
        end
    endtask

    // Advance the model on each edge and record every word the reader takes.
    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            model_reset();
        end else begin
            if (act_oen && ordy) got.push_back({act_olast, act_od});
            model_step();
        end
    end

    // Compare every output against the model on every falling edge.
    initial forever begin
        int n;
        @(negedge clk);
        n = cq.size() + pq.size();
        chk("i_rdy",        act_rdy, m_disc || n < DEPTH);
        chk("count",        act_cnt, n);
        chk("almost_full",  act_af,  n >= (sel ? 3 : 4));
        chk("almost_empty", act_ae,  n <= 1);
        chk("o_en",         act_oen, m_oen);
        if (m_oen) chk("o_word", {act_olast, act_od}, m_out);
        chk("oversize",     act_ovs, m_ovs);
        if (int'(act_cnt) > maxcnt) maxcnt = int'(act_cnt);
        if (act_ovs) ovs_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [7:0] d, input logic l);
        int  t;
        bit  took;
        t    = 0;
        took = 1'b0;
        en   = 1'b1;
        data = d;
        last = l;
        do begin
            took = act_rdy;
            @(negedge clk);
            t++;
        end while (!took && t < 50);
        chk("wr_accept", took, 1'b1);
        en   = 1'b0;
        last = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_i_rdy"},  act_rdy,   1'b1);
        chk({tag, "_count"},  act_cnt,   3'd0);
        chk({tag, "_ae"},     act_ae,    1'b1);
        chk({tag, "_af"},     act_af,    1'b0);
        chk({tag, "_o_en"},   act_oen,   1'b0);
        chk({tag, "_o_data"}, act_od,    8'h00);
        chk({tag, "_o_last"}, act_olast, 1'b0);
        chk({tag, "_ovs"},    act_ovs,   1'b0);
    endtask

    task automatic do_reset(input logic s);
        en   = 1'b0;
        last = 1'b0;
        drop = 1'b0;
        ordy = 1'b0;
        #1 rstn = 1'b0;
        sel = s;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        got.delete();
        maxcnt  = 0;
        ovs_cnt = 0;
    endtask

    task automatic chk_seq(input string name, input logic [8:0] exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, got[i], exp[i]);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [8:0] e[$];

        // Stream: latency, fill, ordering.
        do_reset(1'b0);
        wr(8'h11, 1'b0);
        chk("lat_k", act_oen, 1'b0);
        @(negedge clk);
        chk("lat_k1", act_oen, 1'b0);
        @(negedge clk);
        chk("lat_k2", act_oen, 1'b1);
        chk("lat_data", act_od, 8'h11);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h44, 1'b0);
        chk("full_count", act_cnt, 3'd4);
        chk("full_rdy",   act_rdy, 1'b0);
        chk("full_af",    act_af,  1'b1);
        ordy = 1'b1;
        repeat (6) @(negedge clk);
        ordy = 1'b0;
        e = {9'h011, 9'h022, 9'h033, 9'h044};
        chk_seq("stream_order", e);
        chk("stream_empty", act_cnt, 3'd0);

        // Stream: wrap-around with a random reader.
        do_reset(1'b0);
        fork
            begin
                for (int i = 0; i < 32; i++) wr(8'(i), 1'b0);
            end
            begin
                repeat (90) begin
                    ordy = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
        join
        ordy = 1'b1;
        repeat (12) @(negedge clk);
        ordy = 1'b0;
        e.delete();
        for (int i = 0; i < 32; i++) e.push_back(9'(i));
        chk_seq("wrap_order", e);
        chk("wrap_max_le4", maxcnt <= 4, 1'b1);

        // Packet: nothing visible until commit.
        do_reset(1'b1);
        ordy = 1'b1;
        wr(8'hA0, 1'b0);
        wr(8'hA1, 1'b0);
        chk("pre_commit_oen", act_oen, 1'b0);
        chk("pre_commit_cnt", act_cnt, 3'd2);
        wr(8'hA2, 1'b1);
        chk("vis_k", act_oen, 1'b0);
        @(negedge clk);
        chk("vis_k1", act_oen, 1'b0);
        @(negedge clk);
        chk("vis_k2", act_oen, 1'b1);
        repeat (5) @(negedge clk);
        e = {9'h0A0, 9'h0A1, 9'h1A2};
        chk_seq("commit_order", e);

        // Packet: drop discards only the open packet.
        do_reset(1'b1);
        ordy = 1'b1;
        wr(8'hB0, 1'b0);
        wr(8'hB1, 1'b1);
        wr(8'hC0, 1'b0);
        wr(8'hC1, 1'b0);
        en   = 1'b1;
        data = 8'hC2;
        drop = 1'b1;
        @(negedge clk);
        en   = 1'b0;
        drop = 1'b0;
        repeat (6) @(negedge clk);
        e = {9'h0B0, 9'h1B1};
        chk_seq("drop_order", e);
        chk("drop_count", act_cnt, 3'd0);

        // Packet: oversize packet dropped, the next packet survives.
        do_reset(1'b1);
        ordy = 1'b1;
        for (int i = 0; i < 6; i++) wr(8'h50 + 8'(i), i == 5);
        chk("ovs_pulse", act_ovs, 1'b1);
        chk("ovs_count", act_cnt, 3'd0);
        @(negedge clk);
        chk("ovs_clear", act_ovs, 1'b0);
        chk("ovs_no_oen", got.size(), 0);
        wr(8'h60, 1'b0);
        wr(8'h61, 1'b1);
        repeat (5) @(negedge clk);
        chk("ovs_once", ovs_cnt, 1);
        e = {9'h060, 9'h161};
        chk_seq("ovs_next", e);

        // Packet: asynchronous reset in the middle of a packet.
        do_reset(1'b1);
        ordy = 1'b1;
        wr(8'hD0, 1'b0);
        en   = 1'b1;
        data = 8'hD1;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("mid");
        en = 1'b0;
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("mid_count", act_cnt, 3'd0);
        wr(8'hE0, 1'b0);
        wr(8'hE1, 1'b1);
        repeat (5) @(negedge clk);
        e = {9'h0E0, 9'h1E1};
        chk_seq("mid_next", e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
